dfd_cla_event_gen_mm: RTL and testbench

- Parametrised, multi-mode successor to the CLA event generator.
- Provides NUM_MATCH_UNITS mask/match units. Each unit is independently configurable as level, rising-edge, falling-edge or persistence (N consecutive cycles) detector.
- Also provides registered cross-trigger inputs and the constant Disable/Always-On events.
- Drives the CLA event bus consumed by the CLA trigger/action logic. All generated events are latency-aligned to one cycle.

---
 rtl/dfd_cla_pkg.sv | 20 ++
 rtl/dfd_cla_match_unit.sv | 70 +++++++
 rtl/dfd_cla_event_gen_mm.sv | 69 ++++++
 tb/tb_dfd_cla_event_gen_mm.sv | 226 ++++++++++++++++++++++
 4 files changed

// File: rtl/dfd_cla_pkg.sv
// rtl/dfd_cla_pkg.sv - shared types and event bus layout for the CLA event generator
package dfd_cla_pkg;

    typedef enum logic [1:0] {
        MODE_LEVEL   = 2'd0,
        MODE_RISE    = 2'd1,
        MODE_FALL    = 2'd2,
        MODE_PERSIST = 2'd3
    } cla_match_mode_e;

    // Bits 0/1 are the constant Disable/Always-On events; units start right after
    localparam int MM_MATCH_EVT_BASE = 2;
    localparam int MM_EVTS_PER_UNIT  = 2;

    // First cross-trigger bit position on the event bus for a given unit count
    function automatic int mm_xtrig_evt_pos(input int nUnits);
        return MM_MATCH_EVT_BASE + MM_EVTS_PER_UNIT * nUnits;
    endfunction

endpackage

// File: rtl/dfd_cla_match_unit.sv
// rtl/dfd_cla_match_unit.sv - one mask/match unit with level/edge/persistence detection
module dfd_cla_match_unit
    import dfd_cla_pkg::*;
#(
    parameter int DEBUG_SIGNALS_WIDTH = 64,
    parameter int PERSIST_CNT_WIDTH   = 8
) (
    input  logic                           clock,
    input  logic                           reset_n,
    input  logic [DEBUG_SIGNALS_WIDTH-1:0] debugSignals,
    input  logic                           unitEn,
    input  logic [1:0]                     unitMode,
    input  logic [DEBUG_SIGNALS_WIDTH-1:0] unitMask,
    input  logic [DEBUG_SIGNALS_WIDTH-1:0] unitMatch,
    input  logic [PERSIST_CNT_WIDTH-1:0]   unitThresh,
    input  logic                           cfgUpdate,
    output logic                           primaryEvt,
    output logic                           secondaryEvt
);

    localparam int CW = PERSIST_CNT_WIDTH;

    logic          histVld;
    logic          mPrev;
    logic [CW-1:0] runCnt;

    logic          rawMatch;
    logic          histClear;
    logic [CW-1:0] runCntSat;
    logic [CW:0]   runCntPlusOne;
    logic [CW:0]   effThresh;

    // Compare and persistence arithmetic; the extra bit keeps a saturated counter above threshold
    always_comb begin
        rawMatch      = ((debugSignals & unitMask) == (unitMatch & unitMask));
        histClear     = ~unitEn | cfgUpdate;
        runCntSat     = (&runCnt) ? runCnt : runCnt + CW'(1);
        runCntPlusOne = {1'b0, runCnt} + (CW+1)'(1);
        effThresh     = (unitThresh == '0) ? (CW+1)'(1) : {1'b0, unitThresh};
    end

    // History, run counter and registered events; a clear discards the current sample
    always_ff @(posedge clock or negedge reset_n) begin
        if (!reset_n) begin
            histVld      <= 1'b0;
            mPrev        <= 1'b0;
            runCnt       <= '0;
            primaryEvt   <= 1'b0;
            secondaryEvt <= 1'b0;
        end else if (histClear) begin
            histVld      <= 1'b0;
            mPrev        <= 1'b0;
            runCnt       <= '0;
            primaryEvt   <= 1'b0;
            secondaryEvt <= 1'b0;
        end else begin
            histVld      <= 1'b1;
            mPrev        <= rawMatch;
            runCnt       <= rawMatch ? runCntSat : '0;
            secondaryEvt <= ~rawMatch;
            case (cla_match_mode_e'(unitMode))
                MODE_LEVEL:   primaryEvt <= rawMatch;
                MODE_RISE:    primaryEvt <= histVld & rawMatch & ~mPrev;
                MODE_FALL:    primaryEvt <= histVld & ~rawMatch & mPrev;
                MODE_PERSIST: primaryEvt <= rawMatch & (runCntPlusOne >= effThresh);
            endcase
        end
    end

endmodule

// File: rtl/dfd_cla_event_gen_mm.sv
// rtl/dfd_cla_event_gen_mm.sv - multi-mode CLA event generator driving the CLA event bus
module dfd_cla_event_gen_mm
    import dfd_cla_pkg::*;
#(
    parameter int DEBUG_SIGNALS_WIDTH = 64,
    parameter int NUM_MATCH_UNITS     = 8,
    parameter int PERSIST_CNT_WIDTH   = 8,
    parameter int NUM_XTRIGGER        = 2,
    parameter int EVENT_BUS_WIDTH     = 64
) (
    input  logic                                           clock,
    input  logic                                           reset_n,
    input  logic [DEBUG_SIGNALS_WIDTH-1:0]                 debug_signals,
    input  logic [NUM_MATCH_UNITS-1:0]                     unit_en,
    input  logic [2*NUM_MATCH_UNITS-1:0]                   unit_mode,
    input  logic [NUM_MATCH_UNITS*DEBUG_SIGNALS_WIDTH-1:0] unit_mask,
    input  logic [NUM_MATCH_UNITS*DEBUG_SIGNALS_WIDTH-1:0] unit_match,
    input  logic [NUM_MATCH_UNITS*PERSIST_CNT_WIDTH-1:0]   unit_thresh,
    input  logic [NUM_MATCH_UNITS-1:0]                     cfg_update,
    input  logic [NUM_XTRIGGER-1:0]                        xtrigger_in,
    output logic [EVENT_BUS_WIDTH-1:0]                     event_bus
);

    localparam int DW        = DEBUG_SIGNALS_WIDTH;
    localparam int CW        = PERSIST_CNT_WIDTH;
    localparam int USED_BITS = mm_xtrig_evt_pos(NUM_MATCH_UNITS) + NUM_XTRIGGER;

    if (NUM_MATCH_UNITS < 1 || NUM_MATCH_UNITS > 16) begin : gBadUnitCount
        $error("NUM_MATCH_UNITS must be within 1..16");
    end
    if (EVENT_BUS_WIDTH < USED_BITS) begin : gBusTooNarrow
        $error("EVENT_BUS_WIDTH too small for units plus cross-triggers");
    end

    logic [2*NUM_MATCH_UNITS-1:0] unitEvts;
    logic [NUM_XTRIGGER-1:0]      xtrigReg;

    for (genvar i = 0; i < NUM_MATCH_UNITS; i++) begin : gUnit
        dfd_cla_match_unit #(
            .DEBUG_SIGNALS_WIDTH(DW),
            .PERSIST_CNT_WIDTH  (CW)
        ) uMatchUnit (
            .clock       (clock),
            .reset_n     (reset_n),
            .debugSignals(debug_signals),
            .unitEn      (unit_en[i]),
            .unitMode    (unit_mode[2*i +: 2]),
            .unitMask    (unit_mask[i*DW +: DW]),
            .unitMatch   (unit_match[i*DW +: DW]),
            .unitThresh  (unit_thresh[i*CW +: CW]),
            .cfgUpdate   (cfg_update[i]),
            .primaryEvt  (unitEvts[2*i]),
            .secondaryEvt(unitEvts[2*i+1])
        );
    end

    // Cross-triggers get one register stage to line up with the unit events
    always_ff @(posedge clock or negedge reset_n) begin
        if (!reset_n) begin
            xtrigReg <= '0;
        end else begin
            xtrigReg <= xtrigger_in;
        end
    end

    // Bus layout: {unused zeros, xtriggers, unit event pairs, Always-On=1, Disable=0}
    assign event_bus = EVENT_BUS_WIDTH'({xtrigReg, unitEvts, 2'b10});

endmodule

// File: tb/tb_dfd_cla_event_gen_mm.sv
// tb/tb_dfd_cla_event_gen_mm.sv - directed self-checking bench for dfd_cla_event_gen_mm
module tb_dfd_cla_event_gen_mm;

    localparam int DW = 64;
    localparam int NU = 8;
    localparam int CW = 8;
    localparam int NX = 2;
    localparam int EW = 64;

    logic              clock;
    logic              reset_n;
    logic [DW-1:0]     debug_signals;
    logic [NU-1:0]     unit_en;
    logic [2*NU-1:0]   unit_mode;
    logic [NU*DW-1:0]  unit_mask;
    logic [NU*DW-1:0]  unit_match;
    logic [NU*CW-1:0]  unit_thresh;
    logic [NU-1:0]     cfg_update;
    logic [NX-1:0]     xtrigger_in;
    logic [EW-1:0]     event_bus;

    int checks = 0;
    int errors = 0;

    dfd_cla_event_gen_mm #(
        .DEBUG_SIGNALS_WIDTH(DW),
        .NUM_MATCH_UNITS    (NU),
        .PERSIST_CNT_WIDTH  (CW),
        .NUM_XTRIGGER       (NX),
        .EVENT_BUS_WIDTH    (EW)
    ) dut (
        .clock        (clock),
        .reset_n      (reset_n),
        .debug_signals(debug_signals),
        .unit_en      (unit_en),
        .unit_mode    (unit_mode),
        .unit_mask    (unit_mask),
        .unit_match   (unit_match),
        .unit_thresh  (unit_thresh),
        .cfg_update   (cfg_update),
        .xtrigger_in  (xtrigger_in),
        .event_bus    (event_bus)
    );

    initial clock = 1'b0;
    always #5 clock = ~clock;

    task automatic tick();
        @(posedge clock);
        #1;
    endtask

    task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
        end
    endtask

    task automatic setUnit(input int u, input logic [1:0] mode, input logic [63:0] mask,
                           input logic [63:0] match, input logic [7:0] thr);
        unit_mode[2*u +: 2]    = mode;
        unit_mask[u*DW +: DW]  = mask;
        unit_match[u*DW +: DW] = match;
        unit_thresh[u*CW +: CW] = thr;
    endtask

    initial begin
        reset_n       = 1'b0;
        debug_signals = '0;
        unit_en       = '0;
        unit_mode     = '0;
        unit_mask     = '0;
        unit_match    = '0;
        unit_thresh   = '0;
        cfg_update    = '0;
        xtrigger_in   = '0;

        // Reset state and idle with all units disabled
        #3;
        chk("reset_hold", event_bus, 64'h2);
        repeat (2) @(posedge clock);
        @(negedge clock);
        reset_n = 1'b1;
        tick();
        chk("idle_disabled", event_bus, 64'h2);

        // LEVEL on unit0
        setUnit(0, 2'd0, 64'hFF, 64'h5A, 8'd0);
        unit_en[0]    = 1'b1;
        debug_signals = 64'h5A;
        tick();
        chk("level_match", event_bus, 64'h6);
        debug_signals = 64'h5B;
        tick();
        chk("level_nomatch", event_bus, 64'hA);

        // Asynchronous reset mid-run drops events at once
        #2;
        reset_n = 1'b0;
        #1;
        chk("async_reset", event_bus, 64'h2);
        #1;
        reset_n = 1'b1;
        tick();
        chk("post_reset_level", event_bus, 64'hA);
        unit_en[0] = 1'b0;
        tick();
        chk("unit0_disabled", event_bus, 64'h2);

        // RISE on unit1, FALL on unit3, bit 0 only; first enabled sample is 1
        setUnit(1, 2'd1, 64'h1, 64'h1, 8'd0);
        setUnit(3, 2'd2, 64'h1, 64'h1, 8'd0);
        debug_signals = 64'h1;
        unit_en[1] = 1'b1;
        unit_en[3] = 1'b1;
        tick();
        chk("rise_first_sample_1", event_bus, 64'h2);
        unit_en[1] = 1'b0;
        unit_en[3] = 1'b0;
        tick();
        chk("edge_units_off", event_bus, 64'h2);

        // Sequence 0,1,1,0 starting at enable
        unit_en[1] = 1'b1;
        unit_en[3] = 1'b1;
        debug_signals = 64'h0;
        tick();
        chk("edge_s0", event_bus, 64'h222);
        debug_signals = 64'h1;
        tick();
        chk("edge_s1_rise", event_bus, 64'h12);
        tick();
        chk("edge_s2_hold", event_bus, 64'h2);
        debug_signals = 64'h0;
        tick();
        chk("edge_s3_fall", event_bus, 64'h322);
        unit_en[1] = 1'b0;
        unit_en[3] = 1'b0;
        tick();
        chk("edge_done", event_bus, 64'h2);

        // PERSIST on unit2, threshold 3, match held 5 samples
        setUnit(2, 2'd3, 64'hFF, 64'h33, 8'd3);
        debug_signals = 64'h33;
        unit_en[2] = 1'b1;
        for (int k = 1; k <= 5; k++) begin
            tick();
            chk($sformatf("persist3_s%0d", k), event_bus, (k >= 3) ? 64'h42 : 64'h2);
        end
        debug_signals = 64'h0;
        tick();
        chk("persist3_break", event_bus, 64'h82);

        // Threshold 0 behaves as LEVEL
        unit_en[2] = 1'b0;
        tick();
        chk("persist_off", event_bus, 64'h2);
        setUnit(2, 2'd3, 64'hFF, 64'h33, 8'd0);
        debug_signals = 64'h33;
        unit_en[2] = 1'b1;
        tick();
        chk("persist_thr0", event_bus, 64'h42);

        // cfg_update clears the run when the event would have fired
        setUnit(2, 2'd3, 64'hFF, 64'h33, 8'd3);
        cfg_update[2] = 1'b1;
        tick();
        chk("cfg_clear_a", event_bus, 64'h2);
        cfg_update[2] = 1'b0;
        tick();
        chk("cfg_run_c1", event_bus, 64'h2);
        tick();
        chk("cfg_run_c2", event_bus, 64'h2);
        cfg_update[2] = 1'b1;
        tick();
        chk("cfg_clear_at_cnt2", event_bus, 64'h2);
        cfg_update[2] = 1'b0;
        tick();
        chk("cfg_restart_1", event_bus, 64'h2);
        tick();
        chk("cfg_restart_2", event_bus, 64'h2);
        tick();
        chk("cfg_restart_3", event_bus, 64'h42);

        // Threshold 255 held 300 samples: fires at sample 255 and holds through saturation
        setUnit(2, 2'd3, 64'hFF, 64'h33, 8'd255);
        cfg_update[2] = 1'b1;
        tick();
        chk("thr255_clear", event_bus, 64'h2);
        cfg_update[2] = 1'b0;
        for (int k = 1; k <= 300; k++) begin
            tick();
            chk($sformatf("thr255_s%0d", k), event_bus, (k >= 255) ? 64'h42 : 64'h2);
        end
        unit_en[2] = 1'b0;
        debug_signals = 64'h0;
        tick();
        chk("thr255_off", event_bus, 64'h2);

        // Cross-triggers
        xtrigger_in = 2'b10;
        tick();
        chk("xtrig_10", event_bus, 64'h80002);
        xtrigger_in = 2'b01;
        tick();
        chk("xtrig_01", event_bus, 64'h40002);

        // All units LEVEL with mask 0 plus both xtriggers; upper bits stay 0
        for (int u = 0; u < NU; u++) setUnit(u, 2'd0, 64'h0, 64'h0, 8'd0);
        unit_en     = '1;
        xtrigger_in = 2'b11;
        debug_signals = 64'hDEAD_BEEF_0123_4567;
        tick();
        chk("all_units_xtrig", event_bus, 64'hD5556);
        xtrigger_in = 2'b00;
        unit_en     = '0;
        tick();
        chk("final_idle", event_bus, 64'h2);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
